// File: rtl/lsu_mem.sv
// lsu_mem: load/store unit bridging decoder memory codes to a single-beat word bus.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   start                 request valid, sampled only while idle
//   MemWr / MemRead       store code (01 SW, 10 SB) / load code (01 LW, 10 LB, 11 LBU)
//   addr, wdata           byte address and store data
//   rdata                 load result, held until the next load completes
//   busy, done, err       stall level, completion pulse, rejection/timeout pulse
//   bus_req, bus_we       bus request and direction (1 = write beat)
//   bus_addr, bus_wdata   word-aligned beat address and write data
//   bus_rdata, bus_ack    read data and beat-complete strobe
module lsu_mem #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [1:0]  MemWr,
    input  logic [1:0]  MemRead,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ack
);
    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

    localparam logic [4:0] LIMIT = 5'(TIMEOUT - 1);

    state_t      state;
    logic [1:0]  wr_code;
    logic [1:0]  rd_code;
    logic [1:0]  lane;
    logic [7:0]  sb_byte;
    logic [4:0]  wait_cnt;

    logic        has_op;
    logic        reject;
    logic [7:0]  lane_byte;
    logic [31:0] load_val;
    logic [31:0] merged;

    assign busy = (state != IDLE);

    // Word accesses must be aligned; byte accesses may use any lane.
    assign has_op = (MemWr != 2'b00) || (MemRead != 2'b00);
    assign reject = ((MemWr != 2'b00) && (MemRead != 2'b00)) || (MemWr == 2'b11) ||
                    (((MemRead == 2'b01) || (MemWr == 2'b01)) && (addr[1:0] != 2'b00));

    assign lane_byte = bus_rdata[{lane, 3'b000} +: 8];
    assign load_val  = (rd_code == 2'b01) ? bus_rdata :
                       (rd_code == 2'b10) ? {{24{lane_byte[7]}}, lane_byte} :
                                            {24'h0, lane_byte};

    // Read-modify-write: splice the store byte into the word just read.
    always_comb begin
        merged = bus_rdata;
        merged[{lane, 3'b000} +: 8] = sb_byte;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            wr_code   <= 2'b00;
            rd_code   <= 2'b00;
            lane      <= 2'b00;
            sb_byte   <= 8'h00;
            wait_cnt  <= 5'd0;
            rdata     <= 32'h0;
            done      <= 1'b0;
            err       <= 1'b0;
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            bus_addr  <= 32'h0;
            bus_wdata <= 32'h0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && has_op) begin
                        if (reject) begin
                            err <= 1'b1;
                        end else begin
                            wr_code  <= MemWr;
                            rd_code  <= MemRead;
                            lane     <= addr[1:0];
                            sb_byte  <= wdata[7:0];
                            bus_addr <= {addr[31:2], 2'b00};
                            wait_cnt <= 5'd0;
                            bus_req  <= 1'b1;
                            if (MemWr == 2'b01) begin
                                state     <= WRITE;
                                bus_we    <= 1'b1;
                                bus_wdata <= wdata;
                            end else begin
                                // Loads and SB both begin with a read beat.
                                state  <= READ;
                                bus_we <= 1'b0;
                            end
                        end
                    end
                end
                READ: begin
                    if (bus_ack) begin
                        wait_cnt <= 5'd0;
                        if (wr_code == 2'b10) begin
                            state     <= WRITE;
                            bus_we    <= 1'b1;
                            bus_wdata <= merged;
                        end else begin
                            rdata   <= load_val;
                            state   <= DONE;
                            done    <= 1'b1;
                            bus_req <= 1'b0;
                        end
                    end else if (wait_cnt == LIMIT) begin
                        state   <= IDLE;
                        err     <= 1'b1;
                        bus_req <= 1'b0;
                    end else begin
                        wait_cnt <= wait_cnt + 5'd1;
                    end
                end
                WRITE: begin
                    if (bus_ack) begin
                        wait_cnt <= 5'd0;
                        state    <= DONE;
                        done     <= 1'b1;
                        bus_req  <= 1'b0;
                        bus_we   <= 1'b0;
                    end else if (wait_cnt == LIMIT) begin
                        state   <= IDLE;
                        err     <= 1'b1;
                        bus_req <= 1'b0;
                        bus_we  <= 1'b0;
                    end else begin
                        wait_cnt <= wait_cnt + 5'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_lsu_mem.sv
// tb_lsu_mem: table-driven scoreboard bench for lsu_mem with a programmable bus responder.
module tb_lsu_mem;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  MemWr = 2'b00;
    logic [1:0]  MemRead = 2'b00;
    logic [31:0] addr = 32'h0;
    logic [31:0] wdata = 32'h0;
    logic [31:0] rdata;
    logic        busy, done, err;
    logic        bus_req, bus_we;
    logic [31:0] bus_addr, bus_wdata;
    logic [31:0] bus_rdata = 32'h0;
    logic        bus_ack;

    logic        resp_ack = 1'b0;
    logic        stray_ack = 1'b0;
    assign bus_ack = resp_ack | stray_ack;

    lsu_mem #(.TIMEOUT(16)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .MemWr(MemWr), .MemRead(MemRead),
        .addr(addr), .wdata(wdata), .rdata(rdata), .busy(busy), .done(done), .err(err),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_rdata(bus_rdata), .bus_ack(bus_ack)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [1:0]  wr, rd;
        logic [31:0] addr, wdata, word;
        int          wait_n;
        bit          never;
        bit          exp_err;
        logic [31:0] exp_rdata;
        int          exp_lat;
        bit          exp_wr;
        logic [31:0] exp_wa, exp_wd;
    } vec_t;

    typedef struct {
        vec_t v;
        int   t0;
        int   idx;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int checks = 0;
    int errors = 0;

    // Responder configuration, written only by the stimulus process.
    logic [31:0] cfg_word = 32'h0;
    int          cfg_wait = 0;
    bit          cfg_never = 1'b0;
    int          vid = 0;

    // Responder observations, written only by the responder process.
    int          last_vid = 0;
    int          wcnt = 0;
    bit          req_seen = 1'b0, wr_seen = 1'b0, bad_align = 1'b0;
    logic [31:0] seen_wa = 32'h0, seen_wd = 32'h0, seen_ra = 32'h0;

    always @(negedge clk) begin
        if (vid != last_vid) begin
            last_vid  = vid;
            req_seen  = 1'b0;
            wr_seen   = 1'b0;
            bad_align = 1'b0;
        end
        if (!rst_n) begin
            resp_ack = 1'b0;
            wcnt     = 0;
        end else if (bus_req) begin
            req_seen = 1'b1;
            if (bus_addr[1:0] != 2'b00) bad_align = 1'b1;
            if (!cfg_never && wcnt >= cfg_wait) begin
                resp_ack  = 1'b1;
                wcnt      = 0;
                bus_rdata = cfg_word;
                if (bus_we) begin
                    wr_seen = 1'b1;
                    seen_wa = bus_addr;
                    seen_wd = bus_wdata;
                end else begin
                    seen_ra = bus_addr;
                end
            end else begin
                resp_ack = 1'b0;
                wcnt++;
            end
        end else begin
            resp_ack = 1'b0;
            wcnt     = 0;
        end
    end

    function automatic vec_t mk(logic [1:0] wr, logic [1:0] rd, logic [31:0] a, logic [31:0] wd,
                                logic [31:0] word, int wait_n, bit never, bit exp_err,
                                logic [31:0] exp_rdata, int exp_lat, bit exp_wr,
                                logic [31:0] exp_wa, logic [31:0] exp_wd);
        vec_t v;
        v.wr = wr; v.rd = rd; v.addr = a; v.wdata = wd; v.word = word;
        v.wait_n = wait_n; v.never = never; v.exp_err = exp_err; v.exp_rdata = exp_rdata;
        v.exp_lat = exp_lat; v.exp_wr = exp_wr; v.exp_wa = exp_wa; v.exp_wd = exp_wd;
        return v;
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s vec=%0d actual=%h required=%h", name, idx, act, exp);
        end
    endtask

    task automatic compare(input exp_t e);
        bit reads;
        reads = !e.v.exp_err && ((e.v.rd != 2'b00) || (e.v.wr == 2'b10));
        chk("err", e.idx, 32'(err), 32'(e.v.exp_err));
        chk("done", e.idx, 32'(done), 32'(!e.v.exp_err));
        chk("latency", e.idx, 32'(cyc - e.t0), 32'(e.v.exp_lat));
        chk("rdata", e.idx, rdata, e.v.exp_rdata);
        chk("busy", e.idx, 32'(busy), 32'(!e.v.exp_err));
        chk("bus_req_seen", e.idx, 32'(req_seen), 32'(!(e.v.exp_err && e.v.exp_lat == 1)));
        chk("write_beat", e.idx, 32'(wr_seen), 32'(e.v.exp_wr));
        chk("addr_aligned", e.idx, 32'(bad_align), 32'h0);
        if (e.v.exp_wr) begin
            chk("write_addr", e.idx, seen_wa, e.v.exp_wa);
            chk("write_data", e.idx, seen_wd, e.v.exp_wd);
        end
        if (reads) chk("read_addr", e.idx, seen_ra, {e.v.addr[31:2], 2'b00});
    endtask

    // One clock step; any done/err is matched against the scoreboard head.
    task automatic tick();
        @(negedge clk);
        if (rst_n && (done || err)) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_completion actual=done%0b/err%0b required=none", done, err);
            end else begin
                compare(sb.pop_front());
            end
        end
    endtask

    task automatic drive(input vec_t v, input int idx);
        exp_t e;
        MemWr = v.wr; MemRead = v.rd; addr = v.addr; wdata = v.wdata;
        cfg_word = v.word; cfg_wait = v.wait_n; cfg_never = v.never;
        vid++;
        e.v = v; e.t0 = cyc; e.idx = idx;
        sb.push_back(e);
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_empty(input int idx);
        int n = 0;
        while (sb.size() != 0 && n < 40) begin
            tick();
            n++;
        end
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL completion_timeout vec=%0d actual=no_pulse required=pulse", idx);
            sb.delete();
        end
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        drive(v, idx);
        wait_empty(idx);
        tick();
    endtask

    initial begin
        // LW=01 LB=10 LBU=11 on MemRead; SW=01 SB=10 on MemWr
        vecs.push_back(mk(2'b00, 2'b01, 32'h100, 32'h0, 32'hDEADBEEF, 0, 0, 0, 32'hDEADBEEF, 2, 0, 0, 0));
        vecs.push_back(mk(2'b00, 2'b10, 32'h103, 32'h0, 32'h80123456, 0, 0, 0, 32'hFFFFFF80, 2, 0, 0, 0));
        vecs.push_back(mk(2'b00, 2'b11, 32'h103, 32'h0, 32'h80123456, 0, 0, 0, 32'h00000080, 2, 0, 0, 0));
        vecs.push_back(mk(2'b10, 2'b00, 32'h205, 32'hAB, 32'h11223344, 0, 0, 0, 32'h00000080, 3, 1, 32'h204, 32'h1122AB44));
        vecs.push_back(mk(2'b01, 2'b00, 32'h102, 32'h55, 32'h0, 0, 0, 1, 32'h00000080, 1, 0, 0, 0));
        vecs.push_back(mk(2'b01, 2'b01, 32'h100, 32'h55, 32'h0, 0, 0, 1, 32'h00000080, 1, 0, 0, 0));
        vecs.push_back(mk(2'b11, 2'b00, 32'h100, 32'h55, 32'h0, 0, 0, 1, 32'h00000080, 1, 0, 0, 0));
        vecs.push_back(mk(2'b00, 2'b01, 32'h101, 32'h0, 32'h0, 0, 0, 1, 32'h00000080, 1, 0, 0, 0));
        vecs.push_back(mk(2'b01, 2'b00, 32'h300, 32'hCAFEF00D, 32'h0, 2, 0, 0, 32'h00000080, 4, 1, 32'h300, 32'hCAFEF00D));
        vecs.push_back(mk(2'b00, 2'b10, 32'h102, 32'h0, 32'h007F0000, 1, 0, 0, 32'h0000007F, 3, 0, 0, 0));
        vecs.push_back(mk(2'b00, 2'b11, 32'h201, 32'h0, 32'h0000FF00, 0, 0, 0, 32'h000000FF, 2, 0, 0, 0));
        vecs.push_back(mk(2'b10, 2'b00, 32'h0FF, 32'h123456EE, 32'hAABBCCDD, 1, 0, 0, 32'h000000FF, 5, 1, 32'h0FC, 32'hEEBBCCDD));
        vecs.push_back(mk(2'b00, 2'b01, 32'h400, 32'h0, 32'h0, 0, 1, 1, 32'h000000FF, 17, 0, 0, 0));
        vecs.push_back(mk(2'b10, 2'b00, 32'h401, 32'h77, 32'h0, 0, 1, 1, 32'h000000FF, 17, 0, 0, 0));
        vecs.push_back(mk(2'b00, 2'b10, 32'h000, 32'h0, 32'h000000FF, 0, 0, 0, 32'hFFFFFFFF, 2, 0, 0, 0));

        #1;
        chk("reset_busy", -1, 32'(busy), 0);
        chk("reset_bus_req", -1, 32'(bus_req), 0);
        chk("reset_rdata", -1, rdata, 0);
        chk("reset_bus_addr", -1, bus_addr, 0);
        chk("reset_done_err", -1, 32'({done, err}), 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        foreach (vecs[i]) run_vec(vecs[i], i);

        // Start with no memory code: nothing happens.
        MemWr = 2'b00; MemRead = 2'b00; addr = 32'h100; start = 1'b1;
        tick();
        tick();
        start = 1'b0;
        chk("noop_busy", 100, 32'(busy), 0);
        chk("noop_bus_req", 100, 32'(bus_req), 0);

        // Stray ack while idle is ignored.
        stray_ack = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stray_ack_busy", 101, 32'(busy), 0);
        end
        stray_ack = 1'b0;
        tick();

        // Reset in the middle of a write beat abandons it at once.
        MemWr = 2'b01; MemRead = 2'b00; addr = 32'h500; wdata = 32'h99;
        cfg_never = 1'b1; vid++;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        chk("pre_reset_bus_req", 102, 32'(bus_req), 1);
        chk("pre_reset_bus_we", 102, 32'(bus_we), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset_bus_req", 102, 32'(bus_req), 0);
        chk("async_reset_busy", 102, 32'(busy), 0);
        chk("async_reset_bus_we", 102, 32'(bus_we), 0);
        chk("async_reset_rdata", 102, rdata, 0);
        chk("async_reset_bus_wdata", 102, bus_wdata, 0);
        tick();
        tick();
        rst_n = 1'b1;
        run_vec(mk(2'b00, 2'b01, 32'h104, 32'h0, 32'h12345678, 0, 0, 0, 32'h12345678, 2, 0, 0, 0), 103);

        // Start while busy is ignored: only the first request completes.
        drive(mk(2'b00, 2'b01, 32'h600, 32'h0, 32'h55AA55AA, 3, 0, 0, 32'h55AA55AA, 5, 0, 0, 0), 104);
        MemWr = 2'b01; MemRead = 2'b00; addr = 32'h700; wdata = 32'h1;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_empty(104);
        for (int i = 0; i < 4; i++) tick();
        chk("busy_start_no_write", 104, 32'(wr_seen), 0);
        chk("busy_start_idle", 104, 32'(busy), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
